free_list: RTL and testbench

Physical-register free list for the 2-wide out-of-order core. It sits between the reorder buffer and dispatch. It hands up to two free physical tags per cycle to dispatch through fl_pr0 and fl_pr1, and it takes back up to two stale tags per cycle from ROB retirement. Storage is a 32-entry circular FIFO of 7-bit tags: 64 physical registers, with 32 architecturally mapped out of reset.

---
 rtl/free_list_if.sv | 26 ++
 rtl/free_list.sv | 78 +++++++
 tb/tb_free_list.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/free_list_if.sv
// Dispatch/retire bundle between the ROB, dispatch and the physical-register free list.
// master drives requests and returned tags; slave is the free list.
interface free_list_if #(
  parameter int FL_IDX = 5,
  parameter int PR_W   = 7
);
  logic [1:0]        id_dispatch_num;
  logic [1:0]        fl_retire_num;
  logic [PR_W-1:0]   fl_retire_tag_a;
  logic [PR_W-1:0]   fl_retire_tag_b;
  logic [PR_W-1:0]   fl_pr0;
  logic [PR_W-1:0]   fl_pr1;
  logic [1:0]        fl_cap;
  logic [FL_IDX:0]   fl_count;
  logic              fl_overflow;

  modport master (
    output id_dispatch_num, fl_retire_num, fl_retire_tag_a, fl_retire_tag_b,
    input  fl_pr0, fl_pr1, fl_cap, fl_count, fl_overflow
  );

  modport slave (
    input  id_dispatch_num, fl_retire_num, fl_retire_tag_a, fl_retire_tag_b,
    output fl_pr0, fl_pr1, fl_cap, fl_count, fl_overflow
  );
endinterface

// File: rtl/free_list.sv
// Circular FIFO of free physical tags: hands up to two tags per cycle to dispatch
// and takes back up to two stale tags per cycle from ROB retirement.
module free_list #(
  parameter int FL_SIZE    = 32,
  parameter int FL_IDX     = 5,
  parameter int PR_W       = 7,
  parameter int FIRST_FREE = 32
) (
  input logic         clock,
  input logic         reset,
  free_list_if.slave  fl
);

  localparam logic [FL_IDX:0] SIZE_C = (FL_IDX+1)'(FL_SIZE);
  localparam logic [FL_IDX:0] TWO_C  = (FL_IDX+1)'(2);

  logic [PR_W-1:0]   entry [FL_SIZE];
  logic [FL_IDX-1:0] head;
  logic [FL_IDX-1:0] tail;
  logic [FL_IDX:0]   count;
  logic              overflow;

  logic [1:0]        disp_req;
  logic [1:0]        push_req;
  logic [1:0]        pop;
  logic [1:0]        push_acc;
  logic [FL_IDX:0]   space;
  logic [FL_IDX-1:0] head_p1;
  logic [FL_IDX-1:0] tail_p1;
  logic              drop;

  always_comb begin
    disp_req = (fl.id_dispatch_num == 2'd3) ? 2'd2 : fl.id_dispatch_num;
    push_req = (fl.fl_retire_num == 2'd3) ? 2'd2 : fl.fl_retire_num;

    if (count >= TWO_C) pop = disp_req;
    else                pop = (disp_req < count[1:0]) ? disp_req : count[1:0];

    // slots vacated by this cycle's pops are reusable by this cycle's pushes
    space = SIZE_C - count + (FL_IDX+1)'(pop);

    if (space >= TWO_C) push_acc = push_req;
    else                push_acc = (push_req < space[1:0]) ? push_req : space[1:0];

    drop    = (push_acc != push_req);
    head_p1 = head + FL_IDX'(1);
    tail_p1 = tail + FL_IDX'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FL_SIZE; i++) begin
        entry[i] <= PR_W'(FIRST_FREE + i);
      end
      head     <= '0;
      tail     <= '0;
      count    <= SIZE_C;
      overflow <= 1'b0;
    end else begin
      if (push_acc != 2'd0) entry[tail]    <= fl.fl_retire_tag_a;
      if (push_acc == 2'd2) entry[tail_p1] <= fl.fl_retire_tag_b;
      head  <= head + FL_IDX'(pop);
      tail  <= tail + FL_IDX'(push_acc);
      count <= count - (FL_IDX+1)'(pop) + (FL_IDX+1)'(push_acc);
      if (drop) overflow <= 1'b1;
    end
  end

  // outputs depend on registered state only; pushed tags surface a cycle later
  always_comb begin
    fl.fl_pr0      = entry[head];
    fl.fl_pr1      = entry[head_p1];
    fl.fl_cap      = (count >= TWO_C) ? 2'd2 : count[1:0];
    fl.fl_count    = count;
    fl.fl_overflow = overflow;
  end

endmodule

// File: tb/tb_free_list.sv
// Scoreboard bench for free_list: a queue-based reference model predicts outputs,
// a monitor compares them each cycle against what the DUT presents.
module tb_free_list;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  free_list_if #(.FL_IDX(5), .PR_W(7)) fl_bus ();

  free_list #(.FL_SIZE(32), .FL_IDX(5), .PR_W(7), .FIRST_FREE(32)) dut (
    .clock (clock),
    .reset (reset),
    .fl    (fl_bus)
  );

  typedef struct {
    int pr0;
    int pr1;
    bit v0;
    bit v1;
    int cap;
    int count;
    int ovf;
  } exp_t;

  exp_t expq[$];
  int   model_q[$];
  bit   model_ovf;
  int   errors = 0;
  int   checks = 0;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // reference: pops leave first, then pushes fill whatever room remains
  function automatic void model_step(input bit rst, input int d, input int r,
                                     input int a, input int b);
    int dr, np, pr, sp, acc;
    if (rst) begin
      model_q.delete();
      for (int i = 0; i < 32; i++) model_q.push_back(32 + i);
      model_ovf = 1'b0;
    end else begin
      dr = (d > 2) ? 2 : d;
      np = (dr < model_q.size()) ? dr : model_q.size();
      for (int i = 0; i < np; i++) void'(model_q.pop_front());
      pr  = (r > 2) ? 2 : r;
      sp  = 32 - model_q.size();
      acc = (pr < sp) ? pr : sp;
      if (acc >= 1) model_q.push_back(a);
      if (acc == 2) model_q.push_back(b);
      if (acc < pr) model_ovf = 1'b1;
    end
  endfunction

  task automatic step(input bit rst, input int d, input int r, input int a, input int b);
    exp_t e;
    int   d_v, r_v, a_v, b_v;
    @(negedge clock);
    d_v = d; r_v = r; a_v = a; b_v = b;
    reset                   = rst;
    fl_bus.id_dispatch_num  = d_v[1:0];
    fl_bus.fl_retire_num    = r_v[1:0];
    fl_bus.fl_retire_tag_a  = a_v[6:0];
    fl_bus.fl_retire_tag_b  = b_v[6:0];
    model_step(rst, d, r, a, b);
    e.v0    = (model_q.size() >= 1);
    e.v1    = (model_q.size() >= 2);
    e.pr0   = e.v0 ? model_q[0] : 0;
    e.pr1   = e.v1 ? model_q[1] : 0;
    e.count = model_q.size();
    e.cap   = (model_q.size() >= 2) ? 2 : model_q.size();
    e.ovf   = model_ovf;
    @(posedge clock);
    expq.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("fl_count", int'(fl_bus.fl_count), e.count);
        chk("fl_cap", int'(fl_bus.fl_cap), e.cap);
        chk("fl_overflow", int'(fl_bus.fl_overflow), e.ovf);
        if (e.v0) chk("fl_pr0", int'(fl_bus.fl_pr0), e.pr0);
        if (e.v1) chk("fl_pr1", int'(fl_bus.fl_pr1), e.pr1);
      end
    end
  end

  initial begin : driver
    int mode, d, r;
    fl_bus.id_dispatch_num = '0;
    fl_bus.fl_retire_num   = '0;
    fl_bus.fl_retire_tag_a = '0;
    fl_bus.fl_retire_tag_b = '0;

    // reset and idle
    step(1, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    // dispatch 2 then 1, then drain and retire into an empty list while dispatching
    step(0, 2, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    repeat (16) step(0, 2, 0, 0, 0);
    step(0, 2, 2, 4, 5);
    step(0, 0, 0, 0, 0);

    // FIFO order across head wrap
    step(1, 0, 0, 0, 0);
    step(0, 2, 0, 0, 0);
    step(0, 2, 2, 4, 5);
    repeat (16) step(0, 2, 0, 0, 0);

    // overflow at full, then a full-width retire at count 31 with dispatch 1
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 9, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 2, 10, 11);
    step(0, 0, 2, 12, 13);
    step(0, 3, 3, 14, 15);

    // wrap pointers, then reset while dispatch and retire are both active
    step(1, 0, 0, 0, 0);
    repeat (20) step(0, 2, 1, $urandom_range(0, 127), 0);
    repeat (3) step(0, 2, 0, 0, 0);
    step(1, 2, 2, 100, 101);
    step(0, 0, 0, 0, 0);

    // randomized phases biased toward drain, fill or balance
    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 40 == 0) mode = $urandom_range(0, 2);
      case (mode)
        0:       begin d = $urandom_range(1, 3); r = $urandom_range(0, 1); end
        1:       begin d = $urandom_range(0, 1); r = $urandom_range(1, 3); end
        default: begin d = $urandom_range(0, 3); r = $urandom_range(0, 3); end
      endcase
      step(($urandom_range(0, 199) == 0), d, r,
           $urandom_range(0, 127), $urandom_range(0, 127));
    end

    @(negedge clock);
    #1;
    chk("scoreboard_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
